// File: rtl/obs_histogram_if.sv
// Symbol, read-port and status signals between obs_histogram and its neighbours.
// Optional HIST_SAT_FLAG_EN adds the sat_flag status bit.
interface obs_histogram_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       sym_in;
  logic             sym_vld;
  logic             sym_rdy;
  logic [7:0]       rd_addr;
  logic [CNT_W-1:0] O_out;
  logic             data_rdy;
  logic             rd_done;
`ifdef HIST_SAT_FLAG_EN
  logic             sat_flag;

  modport master (
    output sym_in, sym_vld, rd_addr, rd_done,
    input  sym_rdy, O_out, data_rdy, sat_flag
  );

  modport slave (
    input  sym_in, sym_vld, rd_addr, rd_done,
    output sym_rdy, O_out, data_rdy, sat_flag
  );
`else
  modport master (
    output sym_in, sym_vld, rd_addr, rd_done,
    input  sym_rdy, O_out, data_rdy
  );

  modport slave (
    input  sym_in, sym_vld, rd_addr, rd_done,
    output sym_rdy, O_out, data_rdy
  );
`endif
endinterface

// File: rtl/obs_histogram.sv
// Observed-frequency histogram of 8-bit symbols over a WINDOW_LEN window.
// Define HIST_SAT_FLAG_EN to add a per-window saturation flag (sat_flag).
module obs_histogram #(
  parameter int WINDOW_LEN = 1024,
  parameter int CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  obs_histogram_if.slave bus
);

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, READY} state_t;

  localparam logic [15:0]      LAST_IDX = 16'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] mem [256];
  logic [7:0]       clr_addr;
  logic [15:0]      sample_cnt;
  logic             s1_vld;
  logic [7:0]       s1_addr;
  logic [CNT_W-1:0] s1_data;
  logic             sym_rdy_q;
  logic             data_rdy_q;
  logic [CNT_W-1:0] o_out_q;

  logic             accept;
  logic             at_max;
  logic [CNT_W-1:0] s2_data;
  logic [CNT_W-1:0] fwd_data;
  logic [7:0]       rd_ptr;
  logic [CNT_W-1:0] rd_word;
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [CNT_W-1:0] wr_data;

  assign accept   = bus.sym_vld && sym_rdy_q;
  assign at_max   = (s1_data == CNT_MAX);
  assign s2_data  = at_max ? s1_data : s1_data + CNT_W'(1);

  // Single read port: symbol address while counting, downstream address when READY.
  assign rd_ptr   = (state == READY) ? bus.rd_addr : bus.sym_in;
  assign rd_word  = mem[rd_ptr];

  // A symbol hitting the bin being written this cycle takes the fresh count.
  assign fwd_data = (s1_vld && (s1_addr == bus.sym_in)) ? s2_data : rd_word;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_data = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en = 1'b1;
      end else if (s1_vld) begin
        wr_en   = 1'b1;
        wr_addr = s1_addr;
        wr_data = s2_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      sample_cnt <= '0;
      s1_vld     <= 1'b0;
      s1_addr    <= '0;
      s1_data    <= '0;
      sym_rdy_q  <= 1'b0;
      data_rdy_q <= 1'b0;
      o_out_q    <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_addr <= bus.sym_in;
        s1_data <= fwd_data;
      end
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 8'd1;
          if (clr_addr == 8'hFF) begin
            state     <= ACCUM;
            sym_rdy_q <= 1'b1;
            o_out_q   <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sample_cnt == LAST_IDX) begin
              state      <= DRAIN;
              sym_rdy_q  <= 1'b0;
              sample_cnt <= '0;
            end else begin
              sample_cnt <= sample_cnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          state      <= READY;
          data_rdy_q <= 1'b1;
        end
        READY: begin
          // O_out keeps the last read value through the following clear.
          if (bus.rd_done) begin
            state      <= CLEAR;
            data_rdy_q <= 1'b0;
            clr_addr   <= '0;
          end else begin
            o_out_q <= rd_word;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.sym_rdy  = sym_rdy_q;
  assign bus.data_rdy = data_rdy_q;
  assign bus.O_out    = o_out_q;

`ifdef HIST_SAT_FLAG_EN
  logic sat_q;

  // Set when an increment is clipped at full scale; cleared as the next clear begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (state == READY && bus.rd_done) begin
      sat_q <= 1'b0;
    end else if (s1_vld && at_max) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_obs_histogram.sv
// Directed bench for obs_histogram: four instances cover the window sizes and
// counter widths the scenarios need; sat_flag checks run when HIST_SAT_FLAG_EN is set.
module tb_obs_histogram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst;
  logic [3:0][7:0]  sym;
  logic [3:0]       vld;
  logic [3:0][7:0]  raddr;
  logic [3:0]       done;
  logic [3:0]       rdy;
  logic [3:0]       drdy;
  logic [3:0][15:0] oval;

  int n_checks = 0;
  int n_fail   = 0;

  obs_histogram_if #(.CNT_W(16)) bus0 ();
  obs_histogram_if #(.CNT_W(16)) bus1 ();
  obs_histogram_if #(.CNT_W(16)) bus2 ();
  obs_histogram_if #(.CNT_W(4))  bus3 ();

  obs_histogram #(.WINDOW_LEN(8),  .CNT_W(16)) dut0 (.clk(clk), .rst(rst[0]), .bus(bus0.slave));
  obs_histogram #(.WINDOW_LEN(16), .CNT_W(16)) dut1 (.clk(clk), .rst(rst[1]), .bus(bus1.slave));
  obs_histogram #(.WINDOW_LEN(4),  .CNT_W(16)) dut2 (.clk(clk), .rst(rst[2]), .bus(bus2.slave));
  obs_histogram #(.WINDOW_LEN(20), .CNT_W(4))  dut3 (.clk(clk), .rst(rst[3]), .bus(bus3.slave));

  assign bus0.sym_in = sym[0];  assign bus0.sym_vld = vld[0];
  assign bus0.rd_addr = raddr[0]; assign bus0.rd_done = done[0];
  assign bus1.sym_in = sym[1];  assign bus1.sym_vld = vld[1];
  assign bus1.rd_addr = raddr[1]; assign bus1.rd_done = done[1];
  assign bus2.sym_in = sym[2];  assign bus2.sym_vld = vld[2];
  assign bus2.rd_addr = raddr[2]; assign bus2.rd_done = done[2];
  assign bus3.sym_in = sym[3];  assign bus3.sym_vld = vld[3];
  assign bus3.rd_addr = raddr[3]; assign bus3.rd_done = done[3];

  assign rdy  = {bus3.sym_rdy, bus2.sym_rdy, bus1.sym_rdy, bus0.sym_rdy};
  assign drdy = {bus3.data_rdy, bus2.data_rdy, bus1.data_rdy, bus0.data_rdy};
  assign oval[0] = bus0.O_out;
  assign oval[1] = bus1.O_out;
  assign oval[2] = bus2.O_out;
  assign oval[3] = {12'd0, bus3.O_out};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present a symbol and return just after the edge that accepted it; sym_vld stays high.
  task automatic applyStimulus(input int d, input logic [7:0] s);
    int n = 0;
    sym[d] = s;
    vld[d] = 1'b1;
    while (!rdy[d] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) checkOutput("accept_timeout", 32'(n), 0);
    @(posedge clk); #1;
  endtask

  task automatic waitReady(input int d);
    int n = 0;
    while (!drdy[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("data_rdy_wait", 32'(drdy[d]), 1);
  endtask

  task automatic countClear(input int d, output int n);
    n = 0;
    while (!rdy[d] && n < 400) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic readBin(input int d, input logic [7:0] addr, input logic [15:0] exp_val,
                         input string tag);
    raddr[d] = addr;
    @(posedge clk); #1;
    checkOutput(tag, 32'(oval[d]), 32'(exp_val));
  endtask

  task automatic pulseDone(input int d);
    done[d] = 1'b1;
    @(posedge clk); #1;
    done[d] = 1'b0;
  endtask

  initial begin
    int bad;
    int n;
    logic [7:0] win0 [8];
    win0 = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h07, 8'h07, 8'hFF, 8'h03};
    rst = '1; sym = '0; vld = '0; raddr = '0; done = '0;
    repeat (3) @(posedge clk);
    #1 rst = '0;

    $display("[TB] reset then idle");
    checkOutput("reset_sym_rdy", 32'(rdy), 0);
    checkOutput("reset_data_rdy", 32'(drdy), 0);
    checkOutput("reset_O_out", 32'(oval[0]), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (rdy != 4'b0000 || drdy != 4'b0000 || oval != '0) bad++;
      @(posedge clk); #1;
    end
    checkOutput("clear_quiet_cycles", 32'(bad), 0);
    checkOutput("sym_rdy_after_256", 32'(rdy), 32'hF);
    checkOutput("O_out_zero_accum", 32'(oval[0]), 0);

    $display("[TB] window of 8, back-to-back");
    foreach (win0[i]) applyStimulus(0, win0[i]);
    vld[0] = 1'b0;
    checkOutput("w8_sym_rdy_drop", 32'(rdy[0]), 0);
    checkOutput("w8_drain_no_rdy", 32'(drdy[0]), 0);
    @(posedge clk); #1;
    checkOutput("w8_data_rdy_latency", 32'(drdy[0]), 1);
    readBin(0, 8'h03, 16'd5, "w8_bin03");
    readBin(0, 8'h07, 16'd2, "w8_bin07");
    readBin(0, 8'hFF, 16'd1, "w8_binFF");
    readBin(0, 8'h00, 16'd0, "w8_bin00");

    $display("[TB] window of 16, toggling valid");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'h10);
      vld[1] = 1'b0;
      if (i < 15) begin
        @(posedge clk); #1;
      end
    end
    checkOutput("w16_sym_rdy_drop", 32'(rdy[1]), 0);
    waitReady(1);
    readBin(1, 8'h10, 16'd16, "w16_bin10");
    readBin(1, 8'h0F, 16'd0, "w16_bin0F");
    readBin(1, 8'h11, 16'd0, "w16_bin11");
    readBin(1, 8'h00, 16'd0, "w16_bin00");

    $display("[TB] reset mid-window");
    pulseDone(1);
    checkOutput("w16_done_data_rdy", 32'(drdy[1]), 0);
    countClear(1, n);
    checkOutput("w16_clear_len", 32'(n), 256);
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'h22);
    vld[1] = 1'b0;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    checkOutput("rst_mid_sym_rdy", 32'(rdy[1]), 0);
    checkOutput("rst_mid_data_rdy", 32'(drdy[1]), 0);
    countClear(1, n);
    checkOutput("rst_mid_clear_len", 32'(n), 256);
    for (int i = 0; i < 16; i++) applyStimulus(1, 8'h22);
    vld[1] = 1'b0;
    waitReady(1);
    readBin(1, 8'h22, 16'd16, "rst_mid_bin22");

    $display("[TB] rd_done and next window");
    pulseDone(2);
    checkOutput("rd_done_ignored_accum", 32'(rdy[2]), 1);
    for (int i = 0; i < 4; i++) applyStimulus(2, 8'h10);
    vld[2] = 1'b0;
    waitReady(2);
    readBin(2, 8'h10, 16'd4, "w4_first_bin10");
    pulseDone(2);
    checkOutput("w4_done_data_rdy", 32'(drdy[2]), 0);
    checkOutput("w4_O_out_hold", 32'(oval[2]), 4);
    countClear(2, n);
    checkOutput("w4_clear_len", 32'(n), 256);
    checkOutput("w4_O_out_zero", 32'(oval[2]), 0);
    for (int i = 0; i < 4; i++) applyStimulus(2, 8'h10);
    vld[2] = 1'b0;
    waitReady(2);
    readBin(2, 8'h10, 16'd4, "w4_second_bin10");

    $display("[TB] 4-bit saturation");
    for (int i = 0; i < 20; i++) applyStimulus(3, 8'h01);
    vld[3] = 1'b0;
    waitReady(3);
`ifdef HIST_SAT_FLAG_EN
    checkOutput("sat_flag_set", 32'(bus3.sat_flag), 1);
`endif
    readBin(3, 8'h01, 16'd15, "sat_bin01");
    readBin(3, 8'h00, 16'd0, "sat_bin00");
    readBin(3, 8'h02, 16'd0, "sat_bin02");
    pulseDone(3);
    countClear(3, n);
    checkOutput("sat_clear_len", 32'(n), 256);
`ifdef HIST_SAT_FLAG_EN
    checkOutput("sat_flag_cleared", 32'(bus3.sat_flag), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
